// File: rtl/traffic_phase_arbiter.sv
// Phase scheduler for a four-approach intersection. One approach at a time
// holds the green resource. Requesters are served round-robin, idle
// approaches are skipped, and emergency requests pre-empt the running phase.
// All durations are counted in ticks of the shared divider enable.
//
// state  | meaning
// ALLRED | clearance, all lamps red; picks the next winner
// GREEN  | approach cur is green
// YELLOW | approach cur is yellow; runs to completion
module traffic_phase_arbiter #(
  parameter int unsigned GREEN_MIN = 5,
  parameter int unsigned GREEN_MAX = 20,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned TW        = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] req,
  input  logic [3:0] emg_req,
  output logic [2:0] D1,
  output logic [2:0] D2,
  output logic [2:0] D3,
  output logic [2:0] D4,
  output logic [3:0] grant,
  output logic       phase_start
);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } state_t;

  localparam logic [TW-1:0] L_GMIN = TW'(GREEN_MIN);
  localparam logic [TW-1:0] L_GMAX = TW'(GREEN_MAX);
  localparam logic [TW-1:0] L_YT   = TW'(YELLOW_T);
  localparam logic [TW-1:0] L_ART  = TW'(ALLRED_T);
  localparam logic [TW-1:0] L_ONE  = TW'(1);

  state_t          state, state_nxt;
  logic [TW-1:0]   timer, timer_nxt, elapsed;
  logic [1:0]      last, last_nxt, cur, cur_nxt;
  logic [1:0]      emg_idx, rr_idx, cand;
  logic [3:0]      cur_hot, grant_nxt;
  logic            other_emg, other_req, go_yellow, ps_nxt;
  logic [3:0][2:0] lamp_nxt;

  assign elapsed   = timer + L_ONE;
  assign cur_hot   = 4'b0001 << cur;
  assign other_emg = |(emg_req & ~cur_hot);
  assign other_req = |(req & ~cur_hot);

  // GREEN_MAX rule is kept explicit even though GREEN_MIN normally covers it
  assign go_yellow = other_emg
                  || (!emg_req[cur] && (elapsed >= L_GMIN) && (!req[cur] || other_req))
                  || (!emg_req[cur] && (elapsed >= L_GMAX) && other_req);

  // Winner candidates: lowest emergency bit, and first requester after last
  always_comb begin
    emg_idx = 2'd0;
    rr_idx  = 2'd0;
    cand    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (emg_req[i]) emg_idx = 2'(i);
    end
    // descending offsets so the nearest requester after last is kept
    for (int i = 4; i >= 1; i--) begin
      cand = last + 2'(i);
      if (req[cand]) rr_idx = cand;
    end
  end

  // Next-state and timer logic; everything advances only on tick
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    last_nxt  = last;
    cur_nxt   = cur;
    case (state)
      ST_ALLRED: begin
        if (tick) begin
          if (elapsed >= L_ART) begin
            if (|emg_req) begin
              state_nxt = ST_GREEN;
              cur_nxt   = emg_idx;
              timer_nxt = '0;
            end else if (|req) begin
              state_nxt = ST_GREEN;
              cur_nxt   = rr_idx;
              timer_nxt = '0;
            end else begin
              // hold one short of the limit so every idle tick re-evaluates
              timer_nxt = L_ART - L_ONE;
            end
          end else begin
            timer_nxt = elapsed;
          end
        end
      end
      ST_GREEN: begin
        if (tick) begin
          if (go_yellow) begin
            state_nxt = ST_YELLOW;
            timer_nxt = '0;
          end else begin
            // saturate so an indefinite green never wraps the timer
            timer_nxt = (timer >= L_GMAX) ? L_GMAX : elapsed;
          end
        end
      end
      ST_YELLOW: begin
        if (tick) begin
          if (elapsed >= L_YT) begin
            state_nxt = ST_ALLRED;
            last_nxt  = cur;
            timer_nxt = '0;
          end else begin
            timer_nxt = elapsed;
          end
        end
      end
      default: begin
        state_nxt = ST_ALLRED;
        timer_nxt = '0;
      end
    endcase
  end

  // Output values for the upcoming state, registered alongside it
  always_comb begin
    grant_nxt = 4'b0000;
    lamp_nxt  = {4{3'b100}};
    ps_nxt    = (state != ST_GREEN) && (state_nxt == ST_GREEN);
    if (state_nxt == ST_GREEN) begin
      grant_nxt         = 4'b0001 << cur_nxt;
      lamp_nxt[cur_nxt] = 3'b001;
    end else if (state_nxt == ST_YELLOW) begin
      grant_nxt         = 4'b0001 << cur_nxt;
      lamp_nxt[cur_nxt] = 3'b010;
    end
  end

  // State, timer and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_ALLRED;
      timer       <= '0;
      last        <= 2'd3;
      cur         <= 2'd0;
      grant       <= 4'b0000;
      phase_start <= 1'b0;
      D1          <= 3'b100;
      D2          <= 3'b100;
      D3          <= 3'b100;
      D4          <= 3'b100;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      last        <= last_nxt;
      cur         <= cur_nxt;
      grant       <= grant_nxt;
      phase_start <= ps_nxt;
      D1          <= lamp_nxt[0];
      D2          <= lamp_nxt[1];
      D3          <= lamp_nxt[2];
      D4          <= lamp_nxt[3];
    end
  end

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Bench for traffic_phase_arbiter: two instances (default timing and
// GREEN_MIN=GREEN_MAX=20) driven in parallel against a tick-level reference.
module tb_traffic_phase_arbiter;

  localparam int ALLRED_T = 1;
  localparam int YELLOW_T = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] req;
  logic [3:0] emg_req;
  logic [2:0] a_d1, a_d2, a_d3, a_d4, b_d1, b_d2, b_d3, b_d4;
  logic [3:0] a_grant, b_grant;
  logic       a_ps, b_ps;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0][11:0] lamps;
    logic [1:0][3:0]  grant;
    logic [1:0]       ps;
  } exp_t;
  exp_t exp_q[$];

  int m_state[2];
  int m_app[2];
  int m_last[2];
  int m_cnt[2];
  bit m_ps[2];

  int run_len[2];
  int run_app[2];
  int rlen_a[$], rapp_a[$], rlen_b[$], rapp_b[$];

  always #5 clk = ~clk;

  traffic_phase_arbiter u_dut_a (
    .clk(clk), .rst(rst), .tick(tick), .req(req), .emg_req(emg_req),
    .D1(a_d1), .D2(a_d2), .D3(a_d3), .D4(a_d4),
    .grant(a_grant), .phase_start(a_ps)
  );

  traffic_phase_arbiter #(.GREEN_MIN(20), .GREEN_MAX(20)) u_dut_b (
    .clk(clk), .rst(rst), .tick(tick), .req(req), .emg_req(emg_req),
    .D1(b_d1), .D2(b_d2), .D3(b_d3), .D4(b_d4),
    .grant(b_grant), .phase_start(b_ps)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [11:0] obs_lamps(input int k);
    return (k == 0) ? {a_d4, a_d3, a_d2, a_d1} : {b_d4, b_d3, b_d2, b_d1};
  endfunction

  function automatic logic [3:0] obs_grant(input int k);
    return (k == 0) ? a_grant : b_grant;
  endfunction

  function automatic logic obs_ps(input int k);
    return (k == 0) ? a_ps : b_ps;
  endfunction

  function automatic logic [11:0] exp_lamps(input int k);
    logic [11:0] v;
    v = 12'h924;
    if (m_state[k] == 1) v[m_app[k]*3 +: 3] = 3'b001;
    if (m_state[k] == 2) v[m_app[k]*3 +: 3] = 3'b010;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_app[k] = 0; m_last[k] = 3; m_cnt[k] = 0; m_ps[k] = 0;
      run_len[k] = 0; run_app[k] = 0;
    end
    rlen_a.delete(); rapp_a.delete(); rlen_b.delete(); rapp_b.delete();
  endtask

  task automatic model_tick();
    int w;
    int gmin;
    int gmax;
    logic [3:0] og, orq, hot;
    for (int k = 0; k < 2; k++) begin
      gmin = (k == 0) ? 5 : 20;
      gmax = 20;
      m_cnt[k]++;
      case (m_state[k])
        0: if (m_cnt[k] >= ALLRED_T) begin
          w = -1;
          if (emg_req != 4'b0000) begin
            for (int i = 3; i >= 0; i--) if (emg_req[i]) w = i;
          end else begin
            for (int s = 1; s <= 4; s++)
              if (w < 0 && req[(m_last[k] + s) % 4]) w = (m_last[k] + s) % 4;
          end
          if (w >= 0) begin
            m_state[k] = 1; m_app[k] = w; m_cnt[k] = 0; m_ps[k] = 1;
          end else begin
            m_cnt[k] = ALLRED_T - 1;
          end
        end
        1: begin
          hot = 4'b0001 << m_app[k];
          og  = emg_req & ~hot;
          orq = req & ~hot;
          if (og != 0
              || (!emg_req[m_app[k]] && m_cnt[k] >= gmin && (!req[m_app[k]] || orq != 0))
              || (!emg_req[m_app[k]] && m_cnt[k] >= gmax && orq != 0)) begin
            m_state[k] = 2; m_cnt[k] = 0;
          end
        end
        default: if (m_cnt[k] >= YELLOW_T) begin
          m_state[k] = 0; m_last[k] = m_app[k]; m_cnt[k] = 0;
        end
      endcase
    end
  endtask

  // Record completed green runs (approach, length in ticks) per instance
  task automatic observe_runs();
    int g;
    logic [11:0] lam;
    for (int k = 0; k < 2; k++) begin
      lam = obs_lamps(k);
      g = -1;
      for (int i = 0; i < 4; i++) if (lam[i*3 +: 3] == 3'b001) g = i;
      if (g >= 0) begin
        run_len[k]++; run_app[k] = g;
      end else if (run_len[k] > 0) begin
        if (k == 0) begin rlen_a.push_back(run_len[k]); rapp_a.push_back(run_app[k]); end
        else        begin rlen_b.push_back(run_len[k]); rapp_b.push_back(run_app[k]); end
        run_len[k] = 0;
      end
    end
  endtask

  task automatic cycle(input logic tk);
    exp_t e;
    @(negedge clk);
    tick = tk;
    for (int k = 0; k < 2; k++) m_ps[k] = 0;
    if (tk) model_tick();
    for (int k = 0; k < 2; k++) begin
      e.lamps[k] = exp_lamps(k);
      e.grant[k] = (m_state[k] != 0) ? (4'b0001 << m_app[k]) : 4'b0000;
      e.ps[k]    = m_ps[k];
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    tick = 1'b0;
    e = exp_q.pop_front();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("lamps%0d", k), 32'(obs_lamps(k)), 32'(e.lamps[k]));
      check_eq($sformatf("grant%0d", k), 32'(obs_grant(k)), 32'(e.grant[k]));
      check_eq($sformatf("phase_start%0d", k), 32'(obs_ps(k)), 32'(e.ps[k]));
    end
    if (tk) observe_runs();
  endtask

  task automatic tick_period();
    cycle(1'b1);
    repeat (3) cycle(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    tick = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_run(input string tag, input int idx, input int use_b, input int app, input int len);
    int n;
    n = use_b ? rlen_b.size() : rlen_a.size();
    check_eq({tag, "_count"}, 32'(n > idx), 32'd1);
    if (n > idx) begin
      check_eq({tag, "_app"}, use_b ? rapp_b[idx] : rapp_a[idx], app);
      check_eq({tag, "_len"}, use_b ? rlen_b[idx] : rlen_a[idx], len);
    end
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; req = 4'b0000; emg_req = 4'b0000;
    model_reset();
    #12;
    for (int k = 0; k < 2; k++) begin
      check_eq("rst_lamps", 32'(obs_lamps(k)), 32'h924);
      check_eq("rst_grant", 32'(obs_grant(k)), 32'h0);
      check_eq("rst_ps", 32'(obs_ps(k)), 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;

    // single requester, released at tick 30
    req = 4'b0001;
    repeat (29) tick_period();
    req = 4'b0000;
    repeat (12) tick_period();
    check_run("single", 0, 0, 0, 29);
    check_eq("single_runs", rlen_a.size(), 1);

    // full round robin
    do_reset();
    req = 4'b1111;
    repeat (50) tick_period();
    for (int i = 0; i < 5; i++) check_run("rr", i, 0, i % 4, 5);

    // idle approaches skipped
    do_reset();
    req = 4'b1001;
    repeat (40) tick_period();
    for (int i = 0; i < 4; i++) check_run("skip", i, 0, (i % 2) ? 3 : 0, 5);

    // minimum and maximum green caps
    do_reset();
    req = 4'b0001;
    repeat (2) tick_period();
    req = 4'b0101;
    repeat (28) tick_period();
    check_run("min_a0", 0, 0, 0, 5);
    check_eq("min_a1_app", 32'(rapp_a.size() > 1 ? rapp_a[1] : -1), 32'd2);
    check_run("max_b0", 0, 1, 0, 20);
    check_eq("max_b_d3", 32'(b_d3), 32'(3'b001));

    // emergency pre-emption and hold past GREEN_MAX
    do_reset();
    req = 4'b0001;
    repeat (3) tick_period();
    emg_req = 4'b0100;
    req = 4'b1111;
    repeat (40) tick_period();
    emg_req = 4'b0000;
    repeat (15) tick_period();
    check_run("emg_a0", 0, 0, 0, 3);
    check_run("emg_a1", 1, 0, 2, 36);
    check_run("emg_b0", 0, 1, 0, 3);
    check_run("emg_b1", 1, 1, 2, 36);

    // idle: nothing ever goes green
    do_reset();
    req = 4'b0000;
    repeat (10) tick_period();
    check_eq("idle_runs", rlen_a.size() + run_len[0], 0);

    // asynchronous reset in the middle of a D2 yellow
    do_reset();
    req = 4'b0010;
    tick_period();
    check_eq("d2_grant", 32'(a_grant), 32'h2);
    repeat (6) tick_period();
    req = 4'b0000;
    tick_period();
    cycle(1'b0);
    check_eq("pre_rst_yellow", 32'(a_d2), 32'(3'b010));
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq("async_lamps", 32'(obs_lamps(k)), 32'h924);
      check_eq("async_grant", 32'(obs_grant(k)), 32'h0);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req = 4'b0010;
    tick_period();
    check_eq("post_rst_grant_a", 32'(a_grant), 32'h2);
    check_eq("post_rst_grant_b", 32'(b_grant), 32'h2);
    check_eq("post_rst_d2", 32'(a_d2), 32'(3'b001));
    repeat (3) tick_period();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
